// File: rtl/mdu_div.sv
// Iterative 32-bit divider (DIV/DIVU/REM/REMU), radix-2 restoring, one quotient bit per cycle.
// Optional macro DIV_EARLY_OUT_EN finishes divide-by-zero and signed overflow without iterating.
module mdu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, b_r, quo_r, rem_r, dvsr_r, result_r;
    logic [1:0]       op_r;
    logic [5:0]       cnt_r;
    logic             busy_r, done_r;
    logic             accept_s, early_s;
    logic [WIDTH:0]   shifted_s, diff_s;
    logic [WIDTH-1:0] quo_nxt_s, rem_nxt_s;

    // Magnitude of an operand; only signed operations fold negative values.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // Sign restoration plus divide-by-zero and overflow fix-ups, independent of the iteration.
    function automatic logic [WIDTH-1:0] final_res(input logic [1:0] o,
                                                   input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                                   input logic [WIDTH-1:0] qm, input logic [WIDTH-1:0] rm);
        logic             sgn, div0, ovf;
        logic [WIDTH-1:0] q, r;
        sgn  = ~o[0];
        div0 = (y == {WIDTH{1'b0}});
        ovf  = sgn && (x == {1'b1, {(WIDTH-1){1'b0}}}) && (y == {WIDTH{1'b1}});
        if (div0) begin
            q = {WIDTH{1'b1}};
            r = x;
        end else if (ovf) begin
            q = {1'b1, {(WIDTH-1){1'b0}}};
            r = {WIDTH{1'b0}};
        end else begin
            q = (sgn && (x[WIDTH-1] ^ y[WIDTH-1])) ? -qm : qm;
            r = (sgn && x[WIDTH-1]) ? -rm : rm;
        end
        return o[1] ? r : q;
    endfunction

    // One restoring step: shift the next dividend bit in and try to subtract the divisor.
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, dvsr_r};
        if (!diff_s[WIDTH]) begin
            rem_nxt_s = diff_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[WIDTH-1:0];
            quo_nxt_s = {quo_r[WIDTH-2:0], 1'b0};
        end
    end

    // Start acceptance and the early-out decision for special operands.
    always_comb begin
        accept_s = (state_r == IDLE) && start && !flush;
`ifdef DIV_EARLY_OUT_EN
        early_s  = (b == {WIDTH{1'b0}}) ||
                   (!op[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == {WIDTH{1'b1}}));
`else
        early_s  = 1'b0;
`endif
    end

    // Next-state logic; flush wins over everything else.
    always_comb begin
        state_s = state_r;
        if (flush) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    if (start) state_s = early_s ? DONE : CALC;
                         else       state_s = IDLE;
                CALC:    if (cnt_r == 6'd31) state_s = DONE;
                         else                state_s = CALC;
                DONE:    state_s = IDLE;
                default: state_s = IDLE;
            endcase
        end
    end

    // State, registered status outputs and the division datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
            cnt_r    <= 6'd0;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            op_r     <= 2'd0;
            quo_r    <= {WIDTH{1'b0}};
            rem_r    <= {WIDTH{1'b0}};
            dvsr_r   <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == CALC);
            done_r  <= (state_s == DONE);
            if (flush) begin
                cnt_r <= 6'd0;
            end else if (accept_s) begin
                a_r    <= a;
                b_r    <= b;
                op_r   <= op;
                quo_r  <= mag(a, ~op[0]);
                dvsr_r <= mag(b, ~op[0]);
                rem_r  <= {WIDTH{1'b0}};
                cnt_r  <= 6'd0;
                if (early_s) result_r <= final_res(op, a, b, {WIDTH{1'b0}}, {WIDTH{1'b0}});
            end else if (state_r == CALC) begin
                quo_r <= quo_nxt_s;
                rem_r <= rem_nxt_s;
                cnt_r <= cnt_r + 6'd1;
                if (cnt_r == 6'd31) begin
                    cnt_r    <= 6'd0;
                    result_r <= final_res(op_r, a_r, b_r, quo_nxt_s, rem_nxt_s);
                end
            end
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: arithmetic reference model plus directed literal vectors.
module tb_mdu_div;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    mdu_div #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [31:0] model_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q, r;
        if (y == 32'd0) begin
            q = 32'hFFFF_FFFF; r = x;
        end else if (o[0]) begin
            q = x / y; r = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; r = 32'd0;
        end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end
        return o[1] ? r : q;
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        return (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    endfunction

    // Cycle model: cycles remaining, pending result, expected outputs.
    logic        m_busy = 1'b0, m_done = 1'b0;
    logic [31:0] m_res = 32'd0, m_pend = 32'd0;
    int          m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_res <= 32'd0; m_left <= 0;
        end else if (flush) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1; m_res <= m_pend;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_pend <= model_result(op, a, b);
            if (EARLY && is_special(op, a, b)) begin
                m_done <= 1'b1; m_res <= model_result(op, a, b);
            end else begin
                m_left <= 32; m_busy <= 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("result", result, m_res);
        if (done) done_cnt++;
    end

    // Issue one operation back-to-back after the previous one; optionally poke a stray start while busy.
    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r, input int exp_lat, input int poke_at);
        int lat;
        @(posedge clk);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == poke_at) begin
                op = 2'b01; a = 32'd50; b = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, result, exp_r);
    endtask

    initial begin
        int lat;
        int snap;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("DIVU 100/7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
        run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
        run_op("DIV -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        run_op("REM -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        run_op("DIV 7/-2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 0);
        run_op("REM 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        run_op("DIV -7/-2", 2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 0);
        run_op("DIVU max/1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, 0);
        run_op("DIV -7/0", 2'b00, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, EARLY ? 1 : 33, 0);
        run_op("REM -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, EARLY ? 1 : 33, 0);
        run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5, EARLY ? 1 : 33, 0);
        run_op("DIV ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, EARLY ? 1 : 33, 0);
        run_op("REM ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, EARLY ? 1 : 33, 0);
        run_op("DIVU busy poke", 2'b01, 32'd1000, 32'd3, 32'd333, 33, 5);

        // Flush in cycle N+10 aborts silently and leaves the old result.
        @(posedge clk);
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        snap = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("flush no done", 32'(done_cnt - snap), 32'd0);
        chk("flush result kept", result, 32'd333);

        // Flush and start together: flush wins.
        @(negedge clk);
        op = 2'b01; a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush+start busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-operation, with start held during reset.
        @(negedge clk);
        op = 2'b01; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst result", result, 32'd0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        chk("post-rst idle", {31'd0, busy}, 32'd0);
        run_op("DIVU after rst", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_div.md
MDU_DIV -- requirements
Module: mdu_div

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port a  input  32  dividend; captured when start is accepted.
REQ-007 SHALL have port b  input  32  divisor; captured when start is accepted.
REQ-008 SHALL have port flush  input  1  abort from the pipeline control.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result is valid in that cycle.
REQ-011 SHALL have port result  output  32  quotient or remainder, as selected by op.

Function
REQ-012 SHALL implement FSM states IDLE, CALC and DONE.
REQ-013 SHALL accept start in IDLE when flush=0, latching a, b and op; the accepting edge is cycle N.
REQ-014 SHALL ignore start while busy=1 or done=1; latched operands SHALL remain unchanged.
REQ-015 SHALL perform radix-2 restoring division on operand magnitudes, one quotient bit per cycle, with a 6-bit iteration counter covering 32 iterations.
REQ-016 SHALL hold busy=1 in cycles N+1..N+32 and drive done=1, busy=0 in cycle N+33, then return to IDLE.
REQ-017 SHALL, for DIV and REM, divide absolute values, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-018 SHALL, for b=0, return quotient 0xFFFFFFFF and remainder a, for both signed and unsigned operations.
REQ-019 SHALL, for signed overflow (a=0x80000000, b=0xFFFFFFFF, DIV/REM), return quotient 0x80000000 and remainder 0.
REQ-020 SHALL apply the REQ-018 and REQ-019 results as output fix-ups, independent of the iteration datapath.
REQ-021 SHALL hold result stable from done until the next accepted start.
REQ-022 SHALL, on flush=1 in any state, enter IDLE at the next edge with busy=0 and done=0, suppress the pending done, and leave result unchanged.
REQ-023 SHALL give flush priority over start when both are high in the same cycle.
REQ-024 SHALL accept a start issued in the cycle after done (back-to-back operation).

Reset
REQ-025 SHALL, on rst assertion, immediately force state IDLE, busy=0, done=0, result=0 and counter=0, including mid-operation.
REQ-026 SHALL ignore start while rst is high.

Configuration
REQ-027 SHALL use macro DIV_EARLY_OUT_EN to compile early termination in or out.
REQ-028 SHALL, when DIV_EARLY_OUT_EN is defined, complete b=0 and signed-overflow cases without entering CALC: done=1 in cycle N+1 and busy never asserted.
REQ-029 SHALL, when DIV_EARLY_OUT_EN is undefined, run every operation through the full 33-cycle latency, including the special cases.

Verification
REQ-030 SHALL cover: DIVU a=100, b=7 -> done in cycle N+33, result=14; REMU same operands -> result=2.
REQ-031 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> result=0xFFFFFFFD (-3); REM same operands -> result=0xFFFFFFFF (-1).
REQ-032 SHALL cover: DIV a=0xFFFFFFF9, b=0 -> result=0xFFFFFFFF; REM same operands -> result=0xFFFFFFF9; done at N+1 with the macro defined, N+33 without.
REQ-033 SHALL cover: DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000; REM same operands -> result=0.
REQ-034 SHALL cover: flush at cycle N+10 -> busy=0 at N+11, no done pulse; a second start issued while busy -> ignored, and the first operation's result is unaffected.
REQ-035 SHALL cover: rst asserted at cycle N+5 -> busy, done and result immediately 0; a fresh DIVU 100/7 afterwards -> result 14.
